// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. Operations are
//   accepted over valid/ready, granted round-robin, registered into the ALU
//   inputs for one cycle, and the captured result is returned on a single
//   response channel tagged with the owning requester.
//
//   Handshake rule (all channels): a transfer happens on a rising clock edge
//   where valid and ready are both high; a producer holds its payload stable
//   while valid=1 and ready=0.
//
//   Optional feature: define ALU_ARB_STATS_EN to add the per-requester
//   saturating grant counters gnt_cnt0/gnt_cnt1.
//
//   fsm_state exposes the sequencer state (0 IDLE, 1 EXEC, 2 RESP) for
//   observation only.

module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic [WIDTH-1:0]  alu_scrA,
    output logic [WIDTH-1:0]  alu_scrB,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,

    output logic [1:0]        fsm_state
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CTRL_W-1:0] op_ctrl;
    logic              gnt0;
    logic              gnt1;

    // Round-robin grant, only offered while idle; a tie goes to the
    // requester that did not win last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant) gnt0 = 1'b1;
                else            gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // The ALU always sees registered operands, never the live request buses.
    assign alu_scrA  = op_a;
    assign alu_scrB  = op_b;
    assign alu_ctrl  = op_ctrl;
    assign fsm_state = state;

    // Sequencer: accept -> one ALU cycle -> hold response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_a       <= gnt1 ? req1_a    : req0_a;
                        op_b       <= gnt1 ? req1_b    : req0_b;
                        op_ctrl    <= gnt1 ? req1_ctrl : req0_ctrl;
                        rsp_id     <= gnt1;
                        last_grant <= gnt1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester accept counters that stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt0 && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (gnt1 && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end
`endif

endmodule
